// File: rtl/fuzz_stim_sequencer.sv
// -----------------------------------------------------------------------------
// fuzz_stim_sequencer
//   Hardware stimulus sequencer for the fuzz harness. A 32-bit LCG
//   (state' = state*32'h41C64E6D + 32'h3039, mod 2^32) fills in_flat one
//   32-bit chunk per step, low chunk first. The resulting vector stream is
//   bit-identical to the software harness. Each run presents cycles+1
//   vectors through a valid/ready handshake, then pulses done.
//
// Parameters
//   IN_W      width of in_flat (NWORDS = ceil(IN_W/32) LCG steps per vector)
//   SEED_DEF  LCG seed used when no seed has been loaded since reset
//   CNT_W     width of cycles and vec_count
//
// Ports
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset
//   seed_load_i  in IDLE: load seed_i into the LCG state
//   seed_i       seed value
//   start_i      in IDLE: begin a run (ignored while busy)
//   cycles_i     run length minus one, sampled at start
//   in_flat_o    current stimulus vector
//   vec_valid_o  in_flat_o holds a complete new vector
//   vec_ready_i  consumer accepts the vector (transfer = valid & ready)
//   busy_o       FSM not in IDLE
//   done_o       one-cycle pulse after the last vector is accepted
//   vec_count_o  vectors accepted in the current run (saturating)
//
// Build option
//   FUZZ_STIM_TRACE_EN  when defined, prints every transfer and the end of
//                       each run in simulation. Ports and timing unchanged.
// -----------------------------------------------------------------------------
module fuzz_stim_sequencer #(
  parameter int unsigned IN_W     = 263,
  parameter logic [31:0] SEED_DEF = 32'd1188332531,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             seed_load_i,
  input  logic [31:0]      seed_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cycles_i,
  output logic [IN_W-1:0]  in_flat_o,
  output logic             vec_valid_o,
  input  logic             vec_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] vec_count_o
);

  localparam int unsigned NWORDS = (IN_W + 31) / 32;
  localparam int unsigned WIDX_W = $clog2(NWORDS + 1);
  localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC = 32'h0000_3039;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e             fsm_q;
  logic [31:0]        lcg_q;
  logic [31:0]        lcg_d;
  logic [WIDX_W-1:0]  widx_q;
  logic [CNT_W-1:0]   cycles_q;
  logic [CNT_W-1:0]   vec_count_q;
  logic [CNT_W-1:0]   vec_count_d;
  logic [IN_W-1:0]    in_flat_q;
  logic               vec_valid_q;
  logic               busy_q;
  logic               done_q;
  logic               xfer;

  assign lcg_d       = lcg_q * LCG_MUL + LCG_INC;
  assign xfer        = vec_valid_q & vec_ready_i;
  // Saturating increment; the end-of-run compare still uses this value.
  assign vec_count_d = (&vec_count_q) ? vec_count_q : vec_count_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q       <= S_IDLE;
      lcg_q       <= SEED_DEF;
      widx_q      <= '0;
      cycles_q    <= '0;
      vec_count_q <= '0;
      in_flat_q   <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          // A seed loaded together with start is already in lcg_q when
          // the first FILL step runs.
          if (seed_load_i) lcg_q <= seed_i;
          if (start_i) begin
            fsm_q       <= S_FILL;
            busy_q      <= 1'b1;
            cycles_q    <= cycles_i;
            vec_count_q <= '0;
            widx_q      <= '0;
          end
        end

        S_FILL: begin
          lcg_q <= lcg_d;
          // Bit-wise chunk write so the final chunk is truncated to IN_W.
          for (int unsigned b = 0; b < IN_W; b++) begin
            if ((b / 32) == 32'(widx_q)) in_flat_q[b] <= lcg_d[b % 32];
          end
          if (widx_q == WIDX_W'(NWORDS - 1)) begin
            fsm_q       <= S_PRESENT;
            vec_valid_q <= 1'b1;
          end else begin
            widx_q <= widx_q + WIDX_W'(1);
          end
        end

        S_PRESENT: begin
          if (xfer) begin
            vec_valid_q <= 1'b0;
            vec_count_q <= vec_count_d;
            if (vec_count_d == cycles_q + CNT_W'(1)) begin
              fsm_q  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              fsm_q  <= S_FILL;
              widx_q <= '0;
            end
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          fsm_q  <= S_IDLE;
        end

        default: fsm_q <= S_IDLE;
      endcase
    end
  end

`ifdef FUZZ_STIM_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fsm_q == S_PRESENT && xfer) $write("CYCLE=%0d IN=%0h\n", vec_count_q, in_flat_q);
      if (fsm_q == S_DONE) $display("TB_SIM_OK cycles=%0d", cycles_q);
    end
  end
`else
  // Trace disabled: no simulation output code is compiled.
`endif

  assign in_flat_o   = in_flat_q;
  assign vec_valid_o = vec_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign vec_count_o = vec_count_q;

endmodule
